// File: rtl/ascon_init_loader.sv
// Ascon-128 initialisation loader: collects key/nonce words, starts the init
// permutation, then XORs the key into the permuted state for downstream.
module ascon_init_loader #(
  parameter logic [63:0] IV = 64'h80400C0600000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear_i,
  input  logic            key_reuse_i,
  input  logic            in_valid_i,
  input  logic [31:0]     in_data_i,
  output logic            in_ready_o,
  output logic            perm_start_o,
  output logic [4:0][63:0] perm_state_o,
  input  logic            perm_busy_i,
  input  logic [4:0][63:0] perm_state_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [4:0][63:0] out_state_o,
  output logic            key_loaded_o
);

  typedef enum logic [1:0] {LOAD, START, WAIT, OUT} state_t;

  state_t          state_reg;
  logic [2:0]      idx_reg;
  logic [127:0]    key_reg;
  logic [127:0]    nonce_reg;
  logic            key_loaded_reg;
  logic [4:0][63:0] out_state_reg;

  logic accept;
  logic reuse_hit;

  assign accept    = (state_reg == LOAD) && in_valid_i;
  // A reused key lets the first accepted word land directly in nonce slot 4.
  assign reuse_hit = (idx_reg == 3'd0) && key_reuse_i && key_loaded_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= LOAD;
      idx_reg        <= 3'd0;
      key_reg        <= '0;
      nonce_reg      <= '0;
      key_loaded_reg <= 1'b0;
      out_state_reg  <= '0;
    end else if (clear_i) begin
      state_reg      <= LOAD;
      idx_reg        <= 3'd0;
      key_loaded_reg <= 1'b0;
    end else begin
      case (state_reg)
        LOAD: begin
          if (accept) begin
            if (reuse_hit) begin
              nonce_reg[127:96] <= in_data_i;
              idx_reg           <= 3'd5;
            end else begin
              // Word order is most-significant first, so slot offset is 3-idx.
              if (!idx_reg[2])
                key_reg[{~idx_reg[1:0], 5'd0} +: 32] <= in_data_i;
              else
                nonce_reg[{~idx_reg[1:0], 5'd0} +: 32] <= in_data_i;
              if (idx_reg == 3'd3)
                key_loaded_reg <= 1'b1;
              if (idx_reg == 3'd7) begin
                state_reg <= START;
                idx_reg   <= 3'd0;
              end else begin
                idx_reg <= idx_reg + 3'd1;
              end
            end
          end
        end
        START: state_reg <= WAIT;
        WAIT: begin
          if (!perm_busy_i) begin
            out_state_reg[4] <= perm_state_i[4];
            out_state_reg[3] <= perm_state_i[3];
            out_state_reg[2] <= perm_state_i[2];
            out_state_reg[1] <= perm_state_i[1] ^ key_reg[127:64];
            out_state_reg[0] <= perm_state_i[0] ^ key_reg[63:0];
            state_reg        <= OUT;
          end
        end
        OUT: begin
          if (out_ready_i)
            state_reg <= LOAD;
        end
        default: state_reg <= LOAD;
      endcase
    end
  end

  assign in_ready_o   = (state_reg == LOAD);
  assign perm_start_o = (state_reg == START);
  assign out_valid_o  = (state_reg == OUT);
  assign perm_state_o = {IV, key_reg, nonce_reg};
  assign out_state_o  = out_state_reg;
  assign key_loaded_o = key_loaded_reg;

endmodule

// File: tb/tb_ascon_init_loader.sv
// Bench for ascon_init_loader: directed scenarios plus randomized loads checked
// against a word-level key/nonce model and a fixed-latency core stand-in.
module tb_ascon_init_loader;

  localparam logic [63:0] IV_C = 64'h80400C0600000000;
  localparam int CORE_LAT = 10;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clear_i;
  logic             key_reuse_i;
  logic             in_valid_i;
  logic [31:0]      in_data_i;
  logic             in_ready_o;
  logic             perm_start_o;
  logic [4:0][63:0] perm_state_o;
  logic             perm_busy_i;
  logic [4:0][63:0] perm_state_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [4:0][63:0] out_state_o;
  logic             key_loaded_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int starts = 0;
  int core_cnt = 0;
  logic [4:0][63:0] core_mask = '0;

  // Reference model state
  logic [127:0] mdl_key = '0;
  logic [127:0] mdl_nonce = '0;
  bit           mdl_loaded = 0;
  logic [31:0]  words [8];

  ascon_init_loader dut (
    .clk(clk), .rst_n(rst_n), .clear_i(clear_i), .key_reuse_i(key_reuse_i),
    .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
    .perm_start_o(perm_start_o), .perm_state_o(perm_state_o),
    .perm_busy_i(perm_busy_i), .perm_state_i(perm_state_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_state_o(out_state_o), .key_loaded_o(key_loaded_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Core stand-in: busy for CORE_LAT cycles, result = captured state ^ core_mask.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perm_busy_i  <= 1'b0;
      core_cnt     <= 0;
      perm_state_i <= '0;
    end else if (perm_start_o) begin
      perm_busy_i  <= 1'b1;
      core_cnt     <= CORE_LAT - 1;
      perm_state_i <= perm_state_o ^ core_mask;
      starts       <= starts + 1;
    end else if (perm_busy_i) begin
      if (core_cnt == 0) perm_busy_i <= 1'b0;
      else core_cnt <= core_cnt - 1;
    end
  end

  function automatic logic [4:0][63:0] exp_out(input logic [127:0] k, input logic [127:0] n,
                                               input logic [4:0][63:0] m);
    logic [4:0][63:0] r;
    r = {IV_C, k, n} ^ m;
    r[1] = r[1] ^ k[127:64];
    r[0] = r[0] ^ k[63:0];
    return r;
  endfunction

  task automatic send_word(input logic [31:0] d, input bit reuse);
    int t = 0;
    in_valid_i = 1'b1; in_data_i = d; key_reuse_i = reuse;
    while (!in_ready_o && t < 64) begin @(negedge clk); t++; end
    checks++;
    if (in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL word_accept: in_ready_o=%b required 1 for word %h", in_ready_o, d);
    end
    @(negedge clk);
    in_valid_i = 1'b0; key_reuse_i = 1'b0;
  endtask

  // Full transaction: load words, await result, optional backpressure, handshake.
  task automatic do_txn(input string name, input bit reuse, input bit gapped, input int bp);
    bit eff;
    int n, s0, c_last, t;
    logic [4:0][63:0] exp, hold;
    eff = reuse && mdl_loaded;
    n = eff ? 4 : 8;
    if (eff) mdl_nonce = {words[0], words[1], words[2], words[3]};
    else begin
      mdl_key   = {words[0], words[1], words[2], words[3]};
      mdl_nonce = {words[4], words[5], words[6], words[7]};
      mdl_loaded = 1;
    end
    exp = exp_out(mdl_key, mdl_nonce, core_mask);
    s0 = starts;
    for (int i = 0; i < n; i++) begin
      send_word(words[i], reuse);
      if (gapped && i < n - 1) @(negedge clk);
    end
    c_last = cyc;
    checks++;
    if (in_ready_o !== 1'b0) begin
      errors++; $display("FAIL %s_words: in_ready_o=%b required 0 after %0d words", name, in_ready_o, n);
    end
    t = 0;
    while (!out_valid_o && t < 100) begin @(negedge clk); t++; end
    checks++;
    if (out_valid_o !== 1'b1) begin
      errors++; $display("FAIL %s_timeout: out_valid_o=%b required 1", name, out_valid_o);
      return;
    end
    checks++;
    if (cyc - c_last !== CORE_LAT + 2) begin
      errors++; $display("FAIL %s_latency: cycles=%0d required %0d", name, cyc - c_last, CORE_LAT + 2);
    end
    checks++;
    if (starts - s0 !== 1) begin
      errors++; $display("FAIL %s_start_pulses: got %0d required 1", name, starts - s0);
    end
    checks++;
    if (perm_state_o !== {IV_C, mdl_key, mdl_nonce}) begin
      errors++; $display("FAIL %s_perm_state: got %h required %h", name, perm_state_o, {IV_C, mdl_key, mdl_nonce});
    end
    checks++;
    if (out_state_o !== exp) begin
      errors++; $display("FAIL %s_out_state: got %h required %h", name, out_state_o, exp);
    end
    checks++;
    if (key_loaded_o !== 1'b1) begin
      errors++; $display("FAIL %s_key_loaded: got %b required 1", name, key_loaded_o);
    end
    hold = out_state_o;
    out_ready_i = 1'b0;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid_o !== 1'b1 || out_state_o !== hold || in_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL %s_backpressure: valid=%b ready=%b state=%h required valid=1 ready=0 state=%h",
                 name, out_valid_o, in_ready_o, out_state_o, hold);
      end
    end
    out_ready_i = 1'b1;
    @(negedge clk);
    out_ready_i = 1'b0;
    checks++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      errors++; $display("FAIL %s_handshake: valid=%b in_ready=%b required 0/1", name, out_valid_o, in_ready_o);
    end
    $display("txn %s: reuse=%0b words=%0d bp=%0d out[0]=%h", name, eff, n, bp, out_state_o[0]);
  endtask

  task automatic set_seq_words();
    for (int i = 0; i < 8; i++) begin
      logic [7:0] b;
      b = 8'((i % 4) * 4);
      words[i] = {b, b + 8'd1, b + 8'd2, b + 8'd3};
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || perm_start_o !== 1'b0 ||
        key_loaded_o !== 1'b0 || out_state_o !== '0 || perm_state_o !== {IV_C, 256'd0}) begin
      errors++;
      $display("FAIL %s: ready=%b valid=%b start=%b kl=%b out=%h perm=%h required 1/0/0/0/0/IV,0",
               name, in_ready_o, out_valid_o, perm_start_o, key_loaded_o, out_state_o, perm_state_o);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear_i = 0; key_reuse_i = 0; in_valid_i = 0; in_data_i = '0; out_ready_i = 0;
    #1;
    check_reset_outputs("reset_state");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_released");
  endtask

  task automatic test_full_load();
    core_mask = '0;
    set_seq_words();
    do_txn("full_load", 1'b0, 1'b0, 0);
    checks++;
    if (perm_state_o[4] !== 64'h80400C0600000000 || out_state_o[1:0] !== 128'd0) begin
      errors++; $display("FAIL full_load_vector: x0=%h out[1:0]=%h required IV and 0", perm_state_o[4], out_state_o[1:0]);
    end
  endtask

  task automatic test_key_reuse();
    core_mask = '0;
    for (int i = 0; i < 8; i++) words[i] = 32'hFFFFFFFF;
    do_txn("key_reuse", 1'b1, 1'b0, 0);
    checks++;
    if (out_state_o[0] !== (64'hFFFFFFFFFFFFFFFF ^ 64'h08090A0B0C0D0E0F)) begin
      errors++; $display("FAIL key_reuse_x4: got %h required %h", out_state_o[0],
                         64'hFFFFFFFFFFFFFFFF ^ 64'h08090A0B0C0D0E0F);
    end
  endtask

  task automatic test_backpressure();
    core_mask = '0;
    set_seq_words();
    do_txn("backpressure", 1'b0, 1'b0, 5);
  endtask

  task automatic test_clear_wait();
    bit seen = 0;
    core_mask = '0;
    for (int i = 0; i < 8; i++) words[i] = $urandom;
    for (int i = 0; i < 8; i++) send_word(words[i], 1'b0);
    repeat (4) @(negedge clk);
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    mdl_key = {words[0], words[1], words[2], words[3]};
    mdl_loaded = 0;
    checks++;
    if (key_loaded_o !== 1'b0 || in_ready_o !== 1'b1) begin
      errors++; $display("FAIL clear_wait_state: key_loaded=%b in_ready=%b required 0/1", key_loaded_o, in_ready_o);
    end
    for (int i = 0; i < 20; i++) begin
      if (out_valid_o) seen = 1;
      @(negedge clk);
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL clear_wait_no_output: out_valid_o seen=1 required 0");
    end
    for (int i = 0; i < 8; i++) words[i] = $urandom;
    do_txn("after_clear", 1'b1, 1'b0, 0);
  endtask

  task automatic test_async_reset();
    core_mask = '0;
    for (int i = 0; i < 3; i++) send_word($urandom, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    mdl_key = '0; mdl_nonce = '0; mdl_loaded = 0;
    @(negedge clk);
    rst_n = 1'b1;
    set_seq_words();
    do_txn("after_reset", 1'b0, 1'b0, 0);
  endtask

  task automatic test_gapped();
    core_mask = '0;
    set_seq_words();
    do_txn("gapped", 1'b0, 1'b1, 1);
    checks++;
    if (out_state_o[1:0] !== 128'd0 || out_state_o[3:2] !== {64'h0001020304050607, 64'h08090A0B0C0D0E0F}) begin
      errors++; $display("FAIL gapped_result: got %h", out_state_o);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++) begin
      for (int l = 0; l < 5; l++) core_mask[l] = {$urandom, $urandom};
      for (int i = 0; i < 8; i++) words[i] = $urandom;
      do_txn("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_key_reuse();
    test_backpressure();
    test_clear_wait();
    test_async_reset();
    test_gapped();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
